// File: rtl/range_browse_ctrl_if.sv
// Bus between the browse sequencer and the range Collatz engine.
// range_go/range_start out to range; range_done/range_count back.
interface range_browse_ctrl_if;
  logic        range_go;
  logic [31:0] range_start;
  logic        range_done;
  logic [15:0] range_count;

  modport master (
    output range_go,
    output range_start,
    input  range_done,
    input  range_count
  );

  modport slave (
    input  range_go,
    input  range_start,
    output range_done,
    output range_count
  );
endinterface

// File: rtl/range_browse_ctrl.sv
// Launches a range run from sw, then browses the result RAM.
// Ports: clk, reset, sw, go_btn, add/sub/home pulses, rng (range bus),
//   disp_n/disp_count/disp_valid to the display, busy.
module range_browse_ctrl #(
  parameter int RAM_WORDS     = 256,
  parameter int RAM_ADDR_BITS = 8,
  parameter int READ_LAT      = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [9:0]                 sw,
  input  logic                       go_btn,
  input  logic                       add_pulse,
  input  logic                       sub_pulse,
  input  logic                       home_pulse,
  range_browse_ctrl_if.master        rng,
  output logic [11:0]                disp_n,
  output logic [15:0]                disp_count,
  output logic                       disp_valid,
  output logic                       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_SETTLE,
    S_BROWSE
  } state_t;

  localparam logic [RAM_ADDR_BITS-1:0] OFF_MAX =
    RAM_ADDR_BITS'(RAM_WORDS - 1);
  localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic                     go_btn_q;
  logic                     go_req;
  logic                     go_pend;
  logic [9:0]               base;
  logic [RAM_ADDR_BITS-1:0] offset;
  logic [RAM_ADDR_BITS-1:0] off_nxt;
  logic                     off_chg;
  logic [1:0]               set_cnt;
  logic                     settle_last;
  logic [31:0]              start_q;

  assign go_req      = go_btn & ~go_btn_q;
  assign settle_last = (set_cnt == LAT_LAST);

  // home wins over add/sub; saturated or conflicting
  // add/sub requests produce no offset event at all
  always_comb begin
    off_chg = 1'b0;
    off_nxt = offset;
    if (home_pulse) begin
      off_chg = 1'b1;
      off_nxt = '0;
    end else if (add_pulse && !sub_pulse
                 && offset != OFF_MAX) begin
      off_chg = 1'b1;
      off_nxt = offset + 1'b1;
    end else if (sub_pulse && !add_pulse
                 && offset != '0) begin
      off_chg = 1'b1;
      off_nxt = offset - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (go_req) state_nxt = S_LAUNCH;
      S_LAUNCH:
        state_nxt = S_RUN;
      S_RUN:
        if (rng.range_done) begin
          // a go edge in the done cycle still counts
          if (go_pend || go_req) state_nxt = S_LAUNCH;
          else                   state_nxt = S_SETTLE;
        end
      S_SETTLE:
        if (settle_last) state_nxt = S_BROWSE;
      S_BROWSE:
        if (go_req)       state_nxt = S_LAUNCH;
        else if (off_chg) state_nxt = S_SETTLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rng.range_go = (state == S_LAUNCH);
    busy = (state == S_LAUNCH) || (state == S_RUN);
  end

  assign rng.range_start = start_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      go_btn_q   <= 1'b0;
      go_pend    <= 1'b0;
      base       <= '0;
      offset     <= '0;
      set_cnt    <= '0;
      start_q    <= '0;
      disp_n     <= '0;
      disp_count <= '0;
      disp_valid <= 1'b0;
    end else begin
      go_btn_q <= go_btn;
      disp_n   <= {2'b00, base} + 12'(offset);
      case (state)
        S_LAUNCH: begin
          // base comes from the launched start word so sw is
          // sampled exactly once per run
          base       <= start_q[9:0];
          offset     <= '0;
          disp_valid <= 1'b0;
          go_pend    <= 1'b0;
        end
        S_RUN: begin
          if (go_req) go_pend <= 1'b1;
          if (rng.range_done) start_q <= '0;
        end
        S_SETTLE: begin
          set_cnt <= set_cnt + 1'b1;
          if (settle_last) begin
            set_cnt    <= '0;
            disp_count <= rng.range_count;
            disp_valid <= 1'b1;
          end
        end
        S_BROWSE: begin
          if (!go_req && off_chg) begin
            offset     <= off_nxt;
            start_q    <= 32'(off_nxt);
            disp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
      // launch value is loaded on entry so it is on the
      // bus during the range_go strobe
      if (state_nxt == S_LAUNCH && state != S_LAUNCH)
        start_q <= {22'b0, sw};
    end
  end

endmodule

// File: tb/tb_range_browse_ctrl.sv
// Randomized bench for range_browse_ctrl against an offset/base model.
// Models range as a delayed done strobe plus an async-read result RAM.
module tb_range_browse_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  sw;
  logic        go_btn;
  logic        add_pulse;
  logic        sub_pulse;
  logic        home_pulse;
  logic [11:0] disp_n;
  logic [15:0] disp_count;
  logic        disp_valid;
  logic        busy;

  range_browse_ctrl_if rif ();

  range_browse_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .go_btn     (go_btn),
    .add_pulse  (add_pulse),
    .sub_pulse  (sub_pulse),
    .home_pulse (home_pulse),
    .rng        (rif),
    .disp_n     (disp_n),
    .disp_count (disp_count),
    .disp_valid (disp_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [256];
  int run_left   = 0;
  int done_delay = 20;

  always @(posedge clk) begin
    rif.range_done <= (run_left == 1);
    if (rif.range_go)     run_left <= done_delay;
    else if (run_left > 0) run_left <= run_left - 1;
  end

  assign rif.range_count = ram[rif.range_start[7:0]];

  int n_chk = 0;
  int n_err = 0;
  int m_base;
  int m_off;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_go"},    32'(rif.range_go), 0);
    chk({tag, "_start"}, rif.range_start, 0);
    chk({tag, "_n"},     32'(disp_n), 0);
    chk({tag, "_cnt"},   32'(disp_count), 0);
    chk({tag, "_valid"}, 32'(disp_valid), 0);
    chk({tag, "_busy"},  32'(busy), 0);
  endtask

  task automatic launch(input logic [9:0] v,
                        input int dly,
                        input bit with_home);
    done_delay = dly;
    foreach (ram[i]) ram[i] = 16'($urandom);
    sw         = v;
    go_btn     = 1'b1;
    home_pulse = with_home;
    nc();
    home_pulse = 1'b0;
    chk("launch_go",    32'(rif.range_go), 1);
    chk("launch_start", rif.range_start, 32'(v));
    chk("launch_busy",  32'(busy), 1);
    nc();
    chk("run_go",    32'(rif.range_go), 0);
    chk("run_busy",  32'(busy), 1);
    chk("run_valid", 32'(disp_valid), 0);
    go_btn = 1'b0;
    m_base = v;
    m_off  = 0;
  endtask

  task automatic wait_settled();
    int  t_done;
    bit  ok;
    t_done = -100;
    ok     = 1'b0;
    for (int i = 0; i < 400; i++) begin
      nc();
      if (rif.range_done) t_done = i;
      if (disp_valid) begin
        ok = 1'b1;
        chk("done_to_valid", 32'(i - t_done), 2);
        break;
      end
    end
    if (!ok) chk("settle_timeout", 0, 1);
    chk("settle_busy",  32'(busy), 0);
    chk("settle_cnt",   32'(disp_count), 32'(ram[0]));
    chk("settle_n",     32'(disp_n), 32'(m_base));
    chk("settle_start", rif.range_start, 0);
  endtask

  task automatic browse(input bit a, input bit s, input bit h);
    int  nw;
    bit  chg;
    nw  = m_off;
    chg = 1'b0;
    if (h) begin
      nw = 0; chg = 1'b1;
    end else if (a && !s && m_off < 255) begin
      nw = m_off + 1; chg = 1'b1;
    end else if (s && !a && m_off > 0) begin
      nw = m_off - 1; chg = 1'b1;
    end
    add_pulse  = a;
    sub_pulse  = s;
    home_pulse = h;
    nc();
    add_pulse  = 1'b0;
    sub_pulse  = 1'b0;
    home_pulse = 1'b0;
    chk("bv_mid_valid", 32'(disp_valid), 32'(!chg));
    nc();
    m_off = nw;
    chk("bv_valid", 32'(disp_valid), 1);
    chk("bv_n",     32'(disp_n), 32'(m_base + m_off));
    chk("bv_cnt",   32'(disp_count), 32'(ram[m_off]));
    chk("bv_start", rif.range_start, 32'(m_off));
  endtask

  task automatic rand_browse();
    case ($urandom_range(0, 7))
      0, 1, 2: browse(1, 0, 0);
      3, 4:    browse(0, 1, 0);
      5:       browse(0, 0, 1);
      6:       browse(1, 1, 0);
      default: browse(1, 0, 1);
    endcase
  endtask

  initial begin
    bit seen;
    bit ok;
    reset      = 1'b1;
    sw         = '0;
    go_btn     = 1'b0;
    add_pulse  = 1'b0;
    sub_pulse  = 1'b0;
    home_pulse = 1'b0;
    foreach (ram[i]) ram[i] = '0;
    repeat (3) nc();
    chk_reset_vals("rst");
    reset = 1'b0;
    nc();

    launch(10'd27, 50, 0);
    wait_settled();
    repeat (3) browse(1, 0, 0);
    browse(0, 0, 1);
    browse(0, 1, 0);

    while (m_off < 255) browse(1, 0, 0);
    browse(1, 0, 0);
    browse(1, 1, 0);
    browse(1, 0, 1);

    for (int k = 0; k < 5; k++) begin
      launch(10'($urandom), $urandom_range(3, 60),
             1'($urandom));
      wait_settled();
      repeat (40) rand_browse();
    end

    launch(10'd100, 40, 0);
    repeat (10) nc();
    sw     = 10'd200;
    go_btn = 1'b1;
    seen   = 1'b0;
    ok     = 1'b0;
    for (int i = 0; i < 200; i++) begin
      nc();
      if (disp_valid) seen = 1'b1;
      if (rif.range_go) begin
        ok = 1'b1;
        break;
      end
    end
    chk("pend_relaunch", 32'(ok), 1);
    chk("pend_no_browse", 32'(seen), 0);
    chk("pend_start", rif.range_start, 200);
    go_btn = 1'b0;
    m_base = 200;
    m_off  = 0;
    wait_settled();
    browse(1, 0, 0);

    launch(10'd5, 40, 0);
    repeat (5) nc();
    reset = 1'b1;
    nc();
    chk_reset_vals("rst_run");
    reset = 1'b0;
    repeat (50) nc();
    chk("idle_busy",  32'(busy), 0);
    chk("idle_valid", 32'(disp_valid), 0);
    launch(10'd6, 10, 0);
    wait_settled();

    launch(10'd7, 15, 0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      nc();
      if (rif.range_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("settle_done_seen", 32'(ok), 1);
    nc();
    reset = 1'b1;
    nc();
    chk_reset_vals("rst_settle");
    reset = 1'b0;
    nc();
    launch(10'd1023, 12, 0);
    wait_settled();
    browse(1, 0, 0);
    browse(0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
